// File: rtl/mcctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes, datapath mux selects, ALU operation codes and the ALUOp type.
package mcctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_HALT
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU-control decode: maps ALUOp plus the instruction's
// funct3 / op[5] / funct7b5 fields onto the datapath ALU operation code.
module alu_decoder
   import mcctrl_pkg::*;
(
   input  alu_op_t     alu_op_i,
   input  logic [2:0]  funct3_i,
   input  logic        op5_i,
   input  logic        funct7b5_i,
   output logic [2:0]  alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // Only R-type (op[5] set) may subtract; addi ignores bit 30
               3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RISC-V datapath (lw/sw/R/I/beq/jal).
// Define MCCTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky HALT state.
module multicycle_control
   import mcctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal
);

   state_t  state_q, state_d;
   alu_op_t alu_op;
   logic    pc_update;
   logic    branch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      alu_op    = ALUOP_ADD;
      pc_update = 1'b0;
      branch    = 1'b0;
      case (state_q)
         S_FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            pc_update = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_ITYPE:     state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
               default:      state_d = S_HALT;
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
         S_HALT:  state_d = S_HALT;
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // Branch outcome is resolved in the same cycle the ALU compares rs1/rs2
   assign PCWrite = pc_update | (branch & Zero);

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = IMM_S;
         OP_BEQ:  ImmSrc = IMM_B;
         OP_JAL:  ImmSrc = IMM_J;
         default: ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .op5_i         (op[5]),
      .funct7b5_i    (funct7b5),
      .alu_control_o (ALUControl)
   );

`ifdef MCCTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   assign illegal_d = illegal_q | (state_d == S_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal_q <= 1'b0;
      else        illegal_q <= illegal_d;
   end

   assign Illegal = illegal_q;
`else
   assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised instruction stream against a step-indexed behavioural model,
// plus directed literal checks for lw/sub/addi/beq/sw/illegal/reset cases.
module tb_multicycle_control;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] IT   = 7'b0010011;
   localparam logic [6:0] BEQ  = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;

   localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic       regw;
      logic [1:0] res;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] imm;
      logic [2:0] alu;
      logic       ill;
   } out_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   int   errors = 0;
   int   checks = 0;
   out_t exp_q;
   bit   exp_valid = 1'b0;
   int   cur_step = 0;
   int   cur_cls = 0;
   out_t obs [0:15];
   out_t dut_o;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal)
   );

   assign dut_o = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};

   function automatic bit is_legal(input logic [6:0] o);
      return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BEQ) || (o == JAL);
   endfunction

   function automatic int cpi(input int cls);
      case (cls)
         C_LW:                  return 5;
         C_SW, C_R, C_I, C_JAL: return 4;
         C_BEQ:                 return 3;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
         default:               return 14;
`else
         default:               return 2;
`endif
      endcase
   endfunction

   function automatic logic [2:0] func_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'd0:    return (o[5] && f7) ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected outputs for cycle s of an instruction of class cls
   function automatic out_t model(input int cls, input int s, input logic [6:0] o,
                                  input logic [2:0] f3, input logic f7, input logic z);
      out_t r = '0;
      if (o == SW)       r.imm = 2'd1;
      else if (o == BEQ) r.imm = 2'd2;
      else if (o == JAL) r.imm = 2'd3;
      if (s == 0) begin
         r.irw = 1'b1; r.srcb = 2'd2; r.res = 2'd2; r.pcw = 1'b1;
      end else if (s == 1) begin
         r.srca = 2'd1; r.srcb = 2'd1;
      end else begin
         case (cls)
            C_LW, C_SW: begin
               if (s == 2)        begin r.srca = 2'd2; r.srcb = 2'd1; end
               else if (cls == C_SW) begin r.adr = 1'b1; r.memw = 1'b1; end
               else if (s == 3)   r.adr = 1'b1;
               else               begin r.res = 2'd1; r.regw = 1'b1; end
            end
            C_R: begin
               if (s == 2) begin r.srca = 2'd2; r.alu = func_alu(o, f3, f7); end
               else        r.regw = 1'b1;
            end
            C_I: begin
               if (s == 2) begin r.srca = 2'd2; r.srcb = 2'd1; r.alu = func_alu(o, f3, f7); end
               else        r.regw = 1'b1;
            end
            C_BEQ: begin
               r.srca = 2'd2; r.alu = 3'b001; r.pcw = z;
            end
            C_JAL: begin
               if (s == 2) begin r.srca = 2'd1; r.srcb = 2'd2; r.pcw = 1'b1; end
               else        r.regw = 1'b1;
            end
            default: r.ill = 1'b1;
         endcase
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (exp_valid) begin
         checks++;
         obs[cur_step] = dut_o;
         if (dut_o !== exp_q) begin
            errors++;
            $display("FAIL cycle_compare cls=%0d step=%0d op=%b: got %h required %h",
                     cur_cls, cur_step, op, dut_o, exp_q);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Entered at posedge+1 with the DUT in FETCH; returns at posedge+1
   task automatic run_instr(input int cls, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input int zmode, input int max_steps);
      int n = cpi(cls);
      if (max_steps > 0 && max_steps < n) n = max_steps;
      for (int i = 0; i < 16; i++) obs[i] = 'x;
      op = o; funct3 = f3; funct7b5 = f7;
      cur_cls = cls;
      $display("instr cls=%0d op=%b funct3=%b f7b5=%b steps=%0d", cls, o, f3, f7, n);
      for (int s = 0; s < n; s++) begin
         Zero      = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         cur_step  = s;
         exp_q     = model(cls, s, o, f3, f7, Zero);
         exp_valid = 1'b1;
         @(posedge clk); #1;
      end
      exp_valid = 1'b0;
   endtask

   task automatic do_reset_check();
      exp_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_irwrite", 32'(IRWrite), 32'd1);
      check("rst_regwrite", 32'(RegWrite), 32'd0);
      check("rst_memwrite", 32'(MemWrite), 32'd0);
      check("rst_illegal", 32'(Illegal), 32'd0);
      @(posedge clk); #1;
      check("rst_hold_irwrite", 32'(IRWrite), 32'd1);
      #2 rst_n = 1'b1;
      #1 check("release_irwrite", 32'(IRWrite), 32'd1);
   endtask

   int cnt;
   int cls;
   logic [6:0] ro;

   initial begin
      rst_n = 1'b0; op = LW; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
      @(posedge clk); #1;
      do_reset_check();

      // lw: five cycles, single RegWrite with Data result on the last
      run_instr(C_LW, LW, 3'b010, 1'b0, -1, 0);
      cnt = 0;
      for (int s = 0; s < 5; s++) if (obs[s].regw === 1'b1) cnt++;
      check("lw_regwrite_pulses", cnt, 1);
      check("lw_c5_regwrite", 32'(obs[4].regw), 32'd1);
      check("lw_c5_resultsrc", 32'(obs[4].res), 32'b01);

      run_instr(C_R, RT, 3'b000, 1'b1, -1, 0);
      check("sub_alucontrol", 32'(obs[2].alu), 32'b001);
      run_instr(C_I, IT, 3'b000, 1'b1, -1, 0);
      check("addi_f7_alucontrol", 32'(obs[2].alu), 32'b000);

      run_instr(C_BEQ, BEQ, 3'b000, 1'b0, 1, 0);
      check("beq_taken_pcwrite", 32'(obs[2].pcw), 32'd1);
      check("beq_taken_refetch", 32'(IRWrite), 32'd1);
      run_instr(C_BEQ, BEQ, 3'b000, 1'b0, 0, 0);
      check("beq_nottaken_pcwrite", 32'(obs[2].pcw), 32'd0);
      check("beq_nottaken_refetch", 32'(IRWrite), 32'd1);

      run_instr(C_SW, SW, 3'b010, 1'b0, -1, 0);
      cnt = 0;
      for (int s = 0; s < 4; s++) if (obs[s].memw === 1'b1) cnt++;
      check("sw_memwrite_pulses", cnt, 1);
      check("sw_adrsrc", 32'(obs[3].adr), 32'd1);
      check("sw_immsrc", 32'(obs[3].imm), 32'b01);
      cnt = 0;
      for (int s = 0; s < 4; s++) if (obs[s].regw !== 1'b0) cnt++;
      check("sw_no_regwrite", cnt, 0);

      run_instr(C_ILL, 7'b1111111, 3'b000, 1'b0, -1, 0);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      cnt = 0;
      for (int s = 2; s < 14; s++) if (obs[s].ill === 1'b1) cnt++;
      check("halt_illegal_cycles", cnt, 12);
      check("halt_still_illegal", 32'(Illegal), 32'd1);
      do_reset_check();
`else
      check("illegal_refetch", 32'(IRWrite), 32'd1);
      check("illegal_flag_low", 32'(Illegal), 32'd0);
`endif

      // Abandon a lw in MEMREAD, then a normal instruction must follow
      run_instr(C_LW, LW, 3'b010, 1'b0, -1, 3);
      check("memread_adrsrc", 32'(AdrSrc), 32'd1);
      do_reset_check();
      run_instr(C_R, RT, 3'b111, 1'b0, -1, 0);
      check("post_reset_and", 32'(obs[2].alu), 32'b010);

      for (int n = 0; n < 250; n++) begin
         cls = $urandom_range(0, 6);
         case (cls)
            C_LW:    ro = LW;
            C_SW:    ro = SW;
            C_R:     ro = RT;
            C_I:     ro = IT;
            C_BEQ:   ro = BEQ;
            C_JAL:   ro = JAL;
            default: begin
               ro = 7'($urandom);
               while (is_legal(ro)) ro = 7'($urandom);
            end
         endcase
         run_instr(cls, ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, 0);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
         if (cls == C_ILL) do_reset_check();
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
